// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: multi-lane FIFO decoupling fetch groups from decode, stalls fetch when fewer than ENQ_W slots remain.
module fetch_inst_buffer #(
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 4,
  parameter int DEQ_W  = 4,
  parameter int DATA_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic [ENQ_W-1:0]          i_enq_vld,
  input  logic [ENQ_W*DATA_W-1:0]   i_enq_data,
  output logic                      o_stall,
  output logic [DEQ_W-1:0]          o_deq_vld,
  output logic [DEQ_W*DATA_W-1:0]   o_deq_data,
  input  logic                      i_deq_rdy,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] head, tail, count, n_enq, n_pres;
  logic [DATA_W-1:0] mem [DEPTH];
  logic enq_ok;
  // pointers carry a wrap bit so a full buffer (count == DEPTH) differs from empty
  assign count   = tail - head;
  assign o_count = count;
  assign o_stall = count > PW'(DEPTH - ENQ_W);
  assign enq_ok  = !o_stall && !i_flush;
  assign n_pres  = count < PW'(DEQ_W) ? count : PW'(DEQ_W);
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < ENQ_W; k++) n_enq = n_enq + PW'(i_enq_vld[k]);
  end
  for (genvar k = 0; k < DEQ_W; k++) begin : g_deq
    assign o_deq_vld[k] = (PW'(k) < n_pres) && !i_flush;
    assign o_deq_data[k*DATA_W +: DATA_W] = mem[head[AW-1:0] + AW'(k)];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_W; k++)
      if (enq_ok && PW'(k) < n_enq) mem[tail[AW-1:0] + AW'(k)] <= i_enq_data[k*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_ok) tail <= tail + n_enq;
      if (i_deq_rdy) head <= head + n_pres;
    end
  end
  always @(posedge clk) begin
    if (!rst) begin
      assert ((i_enq_vld & (i_enq_vld + ENQ_W'(1))) == '0);
      assert (count <= PW'(DEPTH));
    end
  end
endmodule
